// File: rtl/bk_pulse_monitor.sv
// bk_pulse_monitor: receive side of the breakdown feedback pulse link.
// Synchronises the asynchronous feedback pulse, measures each pulse's high
// width and rise-to-rise period, checks both against acceptance windows and
// reports per-pulse verdicts, a qualified link-OK status and loss of pulse.
//
// Ports:
//   i_clk_25m     25 MHz clock, all logic on its rising edge
//   i_rst         synchronous active-high reset
//   i_bk_pulse    asynchronous feedback pulse
//   o_width       last measured high width, in clocks
//   o_period      last measured rise-to-rise period, in clocks
//   o_meas_valid  one-cycle strobe marking a new o_width/o_period report
//   o_pulse_good  verdict for the current report (valid with o_meas_valid)
//   o_ok          link qualified after P_GOOD_CNT consecutive good reports
//   o_lost        no rising edge seen for P_TIMEOUT clocks
module bk_pulse_monitor #(
  parameter int unsigned P_CNT_W      = 20,
  parameter int unsigned P_WIDTH_MIN  = 700,
  parameter int unsigned P_WIDTH_MAX  = 1050,
  parameter int unsigned P_PERIOD_MIN = 475000,
  parameter int unsigned P_PERIOD_MAX = 525000,
  parameter int unsigned P_TIMEOUT    = 750000,
  parameter int unsigned P_GOOD_CNT   = 3
) (
  input  logic               i_clk_25m,
  input  logic               i_rst,
  input  logic               i_bk_pulse,
  output logic [P_CNT_W-1:0] o_width,
  output logic [P_CNT_W-1:0] o_period,
  output logic               o_meas_valid,
  output logic               o_pulse_good,
  output logic               o_ok,
  output logic               o_lost
);

  localparam int unsigned GOOD_W = $clog2(P_GOOD_CNT + 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 hist_q, hist_d;
  logic [1:0]           fill_q, fill_d;
  logic                 armed_q, armed_d;
  logic [P_CNT_W-1:0]   width_cnt_q, width_cnt_d;
  logic [P_CNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic [P_CNT_W-1:0]   width_lat_q, width_lat_d;
  logic                 width_ok_q, width_ok_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
  logic [P_CNT_W-1:0]   width_q, width_d;
  logic [P_CNT_W-1:0]   period_q, period_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 pulse_good_q, pulse_good_d;
  logic                 ok_q, ok_d;
  logic                 lost_q, lost_d;

  logic                 rise_c;
  logic                 fall_c;
  logic                 timeout_c;
  logic                 period_in_win_c;
  logic                 width_in_win_c;

  assign o_width      = width_q;
  assign o_period     = period_q;
  assign o_meas_valid = meas_valid_q;
  assign o_pulse_good = pulse_good_q;
  assign o_ok         = ok_q;
  assign o_lost       = lost_q;

  // Edge detection on the synchronised signal; rises only count once armed.
  assign rise_c    = armed_q & sync2_q & ~hist_q;
  assign fall_c    = ~sync2_q & hist_q;
  assign timeout_c = (period_cnt_q == P_CNT_W'(P_TIMEOUT));

  assign width_in_win_c  = (width_cnt_q >= P_CNT_W'(P_WIDTH_MIN)) &&
                           (width_cnt_q <= P_CNT_W'(P_WIDTH_MAX));
  assign period_in_win_c = (period_cnt_q >= P_CNT_W'(P_PERIOD_MIN)) &&
                           (period_cnt_q <= P_CNT_W'(P_PERIOD_MAX));

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    sync1_d      = i_bk_pulse;
    sync2_d      = sync1_q;
    hist_d       = sync2_q;
    fill_d       = {fill_q[0], 1'b1};
    armed_d      = armed_q;
    width_cnt_d  = width_cnt_q;
    period_cnt_d = period_cnt_q;
    width_lat_d  = width_lat_q;
    width_ok_d   = width_ok_q;
    good_cnt_d   = good_cnt_q;
    width_d      = width_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    pulse_good_d = pulse_good_q;
    ok_d         = ok_q;
    lost_d       = lost_q;

    // The synchroniser stages are zero straight after reset, so a low is only
    // believed once both stages hold real samples of the pin.
    if (fill_q[1] && !sync2_q) begin
      armed_d = 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        if (rise_c) begin
          width_cnt_d  = P_CNT_W'(1);
          period_cnt_d = P_CNT_W'(1);
          lost_d       = 1'b0;
          state_d      = S_HIGH;
        end
      end

      S_HIGH: begin
        if (timeout_c) begin
          lost_d     = 1'b1;
          good_cnt_d = '0;
          ok_d       = 1'b0;
          state_d    = S_WAIT;
        end else begin
          width_cnt_d  = width_cnt_q + P_CNT_W'(1);
          period_cnt_d = period_cnt_q + P_CNT_W'(1);
          if (fall_c) begin
            width_lat_d = width_cnt_q;
            width_ok_d  = width_in_win_c;
            state_d     = S_LOW;
          end
        end
      end

      S_LOW: begin
        // A rise on the timeout cycle still reports, with a saturated period.
        if (rise_c) begin
          width_d      = width_lat_q;
          period_d     = period_cnt_q;
          meas_valid_d = 1'b1;
          pulse_good_d = width_ok_q & period_in_win_c;
          if (width_ok_q && period_in_win_c) begin
            if (good_cnt_q != GOOD_W'(P_GOOD_CNT)) begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            good_cnt_d = '0;
          end
          ok_d         = (good_cnt_d == GOOD_W'(P_GOOD_CNT));
          width_cnt_d  = P_CNT_W'(1);
          period_cnt_d = P_CNT_W'(1);
          state_d      = S_HIGH;
        end else if (timeout_c) begin
          lost_d     = 1'b1;
          good_cnt_d = '0;
          ok_d       = 1'b0;
          state_d    = S_WAIT;
        end else begin
          period_cnt_d = period_cnt_q + P_CNT_W'(1);
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk_25m) begin
    if (i_rst) begin
      state_q      <= S_WAIT;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      width_cnt_q  <= '0;
      period_cnt_q <= '0;
      width_lat_q  <= '0;
      width_ok_q   <= 1'b0;
      good_cnt_q   <= '0;
      width_q      <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      pulse_good_q <= 1'b0;
      ok_q         <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      width_cnt_q  <= width_cnt_d;
      period_cnt_q <= period_cnt_d;
      width_lat_q  <= width_lat_d;
      width_ok_q   <= width_ok_d;
      good_cnt_q   <= good_cnt_d;
      width_q      <= width_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      pulse_good_q <= pulse_good_d;
      ok_q         <= ok_d;
      lost_q       <= lost_d;
    end
  end

endmodule

// File: tb/tb_bk_pulse_monitor.sv
// Testbench for bk_pulse_monitor with scaled-down timing windows.
// Expected events are derived from the pin rise times and pulse shapes and
// queued; a monitor pops and compares on every report, loss and loss-clear.
module tb_bk_pulse_monitor;

  localparam int unsigned CW   = 10;
  localparam int unsigned WMIN = 7;
  localparam int unsigned WMAX = 10;
  localparam int unsigned PMIN = 47;
  localparam int unsigned PMAX = 52;
  localparam int unsigned TMO  = 75;
  localparam int unsigned GC   = 3;

  localparam int K_REP  = 0;
  localparam int K_LOST = 1;
  localparam int K_CLR  = 2;

  typedef struct {
    int kind;
    int w;
    int p;
    int good;
    int ok;
    int at;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pin;
  logic [CW-1:0] o_width;
  logic [CW-1:0] o_period;
  logic          o_meas_valid;
  logic          o_pulse_good;
  logic          o_ok;
  logic          o_lost;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  logic lost_prev = 1'b0;

  // Reference state: timing of accepted rises and qualification count.
  bit  have_prev = 0;
  bit  lost_m = 0;
  int  prev_rise = 0;
  int  prev_w = 0;
  int  good_cnt_m = 0;

  bk_pulse_monitor #(
    .P_CNT_W     (CW),
    .P_WIDTH_MIN (WMIN),
    .P_WIDTH_MAX (WMAX),
    .P_PERIOD_MIN(PMIN),
    .P_PERIOD_MAX(PMAX),
    .P_TIMEOUT   (TMO),
    .P_GOOD_CNT  (GC)
  ) dut (
    .i_clk_25m   (clk),
    .i_rst       (rst),
    .i_bk_pulse  (pin),
    .o_width     (o_width),
    .o_period    (o_period),
    .o_meas_valid(o_meas_valid),
    .o_pulse_good(o_pulse_good),
    .o_ok        (o_ok),
    .o_lost      (o_lost)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int w, input int p,
                      input int good, input int ok, input int at);
    ev_t e;
    e.kind = kind; e.w = w; e.p = p; e.good = good; e.ok = ok; e.at = at;
    exp_q.push_back(e);
  endtask

  // Called at the negedge where the pin goes high; the DUT reacts 3 clocks
  // later. A pulse of h high + l low clocks times out if the next rise lies
  // beyond TMO clocks.
  task automatic model_rise(input int h, input int l);
    int n;
    int p;
    int good;
    n = cyc;
    if (have_prev) begin
      p = n - prev_rise;
      good = (prev_w >= int'(WMIN) && prev_w <= int'(WMAX) &&
              p >= int'(PMIN) && p <= int'(PMAX)) ? 1 : 0;
      if (good == 1) good_cnt_m = (good_cnt_m < int'(GC)) ? good_cnt_m + 1 : int'(GC);
      else           good_cnt_m = 0;
      push(K_REP, prev_w, p, good, (good_cnt_m == int'(GC)) ? 1 : 0, n + 3);
    end else if (lost_m) begin
      push(K_CLR, 0, 0, 0, 0, n + 3);
      lost_m = 0;
    end
    if (h + l > int'(TMO)) begin
      push(K_LOST, 0, 0, 0, 0, n + 3 + int'(TMO));
      lost_m     = 1;
      have_prev  = 0;
      good_cnt_m = 0;
    end else begin
      have_prev = 1;
      prev_rise = n;
      prev_w    = h;
    end
  endtask

  task automatic pulse(input int h, input int l);
    model_rise(h, l);
    pin = 1'b1;
    repeat (h) @(negedge clk);
    pin = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " o_width"},      int'(o_width), 0);
    chk({tag, " o_period"},     int'(o_period), 0);
    chk({tag, " o_meas_valid"}, int'(o_meas_valid), 0);
    chk({tag, " o_pulse_good"}, int'(o_pulse_good), 0);
    chk({tag, " o_ok"},         int'(o_ok), 0);
    chk({tag, " o_lost"},       int'(o_lost), 0);
  endtask

  task automatic handle(input int kind, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d, none expected", name, cyc);
    end else begin
      e = exp_q.pop_front();
      chk({name, " kind"},  kind, e.kind);
      chk({name, " cycle"}, cyc, e.at);
      if (e.kind == K_REP && kind == K_REP) begin
        chk("report width",  int'(o_width), e.w);
        chk("report period", int'(o_period), e.p);
        chk("report good",   int'(o_pulse_good), e.good);
        chk("report ok",     int'(o_ok), e.ok);
        chk("report lost",   int'(o_lost), 0);
      end else if (e.kind == K_LOST && kind == K_LOST) begin
        chk("lost ok", int'(o_ok), 0);
      end
    end
  endtask

  // Monitor: compares every observable event against the expectation queue.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (o_meas_valid) handle(K_REP, "report");
      if (o_lost && !lost_prev) handle(K_LOST, "lost");
      if (!o_lost && lost_prev) handle(K_CLR, "lost clear");
    end
    lost_prev = o_lost;
  end

  initial begin
    int r;
    int h;
    int p;
    rst = 1'b1;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Nominal stream, then a narrow pulse and requalification.
    repeat (5) pulse(9, 41);
    pulse(5, 45);
    repeat (4) pulse(9, 41);
    // Short period, glitch, and period exactly at the timeout.
    pulse(9, 31);
    pulse(1, 49);
    pulse(9, 41);
    pulse(9, int'(TMO) - 9);
    pulse(9, 41);
    // Pulses stop: loss, then recovery.
    pulse(9, int'(TMO) - 8);
    pulse(9, 41);
    pulse(9, 41);
    // Stuck high through the timeout.
    pulse(int'(TMO) + 20, 10);
    pulse(9, 41);

    // Reset pulsed mid-high with the pin held high.
    model_rise(30, 10);
    pin = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid-pulse reset");
    rst = 1'b0;
    have_prev  = 0;
    lost_m     = 0;
    good_cnt_m = 0;
    repeat (10) @(negedge clk);
    pin = 1'b0;
    repeat (10) @(negedge clk);
    pulse(9, 41);
    pulse(9, 41);
    pulse(9, 41);

    // Randomised pulse shapes around the window boundaries.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        h = int'($urandom_range(WMIN - 1, WMAX + 1));
        p = int'($urandom_range(PMIN - 1, PMAX + 1));
      end else if (r == 6) begin
        h = int'($urandom_range(1, 6));
        p = int'($urandom_range(20, 60));
      end else if (r == 7) begin
        h = 8;
        p = int'($urandom_range(PMAX + 1, TMO + 2));
      end else if (r == 8) begin
        h = int'($urandom_range(WMIN, WMAX));
        p = int'($urandom_range(PMIN, PMAX));
      end else begin
        h = 9;
        p = int'(TMO) + int'($urandom_range(1, 20));
      end
      pulse(h, p - h);
    end

    pulse(9, int'(TMO) + 10);
    repeat (10) @(negedge clk);
    chk("pending expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bk_pulse_monitor.md
Name: bk_pulse_monitor

Overview:
- Receiving end of the breakdown feedback pulse link.
- Synchronises the asynchronous feedback pulse into the 25 MHz domain, then measures each pulse's high width and its rise-to-rise period.
- Checks both measurements against acceptance windows and reports per-pulse results, a qualified "link OK" status and a loss-of-pulse fault.
- Sits between the feedback input pin and the breakdown supervision logic.

Parameters:
- P_CNT_W, 20, width of the width/period counters and result outputs.
- P_WIDTH_MIN, 700, minimum acceptable high width, in clocks.
- P_WIDTH_MAX, 1050, maximum acceptable high width, in clocks.
- P_PERIOD_MIN, 475000, minimum acceptable rise-to-rise period, in clocks.
- P_PERIOD_MAX, 525000, maximum acceptable rise-to-rise period, in clocks.
- P_TIMEOUT, 750000, clocks without a rising edge before loss is declared. Must be greater than P_PERIOD_MAX and less than 2^P_CNT_W.
- P_GOOD_CNT, 3, consecutive good reports required before o_ok asserts.

Ports:
- i_clk_25m  in  1  25 MHz clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_bk_pulse  in  1  asynchronous breakdown feedback pulse.
- o_width  out  P_CNT_W  last measured high width, in clocks.
- o_period  out  P_CNT_W  last measured rise-to-rise period, in clocks.
- o_meas_valid  out  1  one-cycle strobe; o_width and o_period are updated on the same cycle.
- o_pulse_good  out  1  verdict for the current report; meaningful only while o_meas_valid=1.
- o_ok  out  1  link qualified after P_GOOD_CNT consecutive good reports.
- o_lost  out  1  no rising edge seen for P_TIMEOUT clocks.

Behaviour:
- Reset: synchronous and active-high. Every output, counter, synchroniser stage and the good count go to 0. State goes to S_WAIT with armed=0.
- Input path: two-flop synchroniser followed by one history flop.
  - rise = sync2 & ~hist; fall = ~sync2 & hist.
  - A rise is detected 3 clocks after the input edge. Width and period measure the synchronised signal.
- armed: set the first cycle sync2=0 is seen. Rises are ignored while armed=0, so an input held high through reset is never taken as an edge.
- Counters:
  - width_cnt and period_cnt both load 1 on an accepted rise.
  - width_cnt increments while in S_HIGH.
  - period_cnt increments in S_HIGH and S_LOW and saturates at P_TIMEOUT.
- State S_WAIT:
  - On an armed rise: go to S_HIGH and clear o_lost.
  - No report is produced, because no prior rise exists to measure a period from.
- State S_HIGH:
  - On fall: latch width = width_cnt, set width_ok = (P_WIDTH_MIN <= width <= P_WIDTH_MAX), go to S_LOW.
- State S_LOW, on rise:
  - o_width <= latched width; o_period <= period_cnt; o_meas_valid <= 1 for one cycle.
  - o_pulse_good <= width_ok & (P_PERIOD_MIN <= period_cnt <= P_PERIOD_MAX).
  - Reload counters, stay on the new pulse, go to S_HIGH.
- Timeout: in S_HIGH or S_LOW, when period_cnt = P_TIMEOUT with no rise on that cycle:
  - o_lost <= 1, good count <= 0, o_ok <= 0, go to S_WAIT.
  - This also covers an input stuck high.
- Simultaneous rise and timeout: the rise has priority. A report is produced with o_period = P_TIMEOUT and o_pulse_good = 0.
- Good-count qualification:
  - Each good report increments a counter that saturates at P_GOOD_CNT.
  - Any bad report clears the counter to 0.
  - o_ok = 1 exactly when the counter equals P_GOOD_CNT, registered on the same cycle as the report.
- Reports are produced only on S_LOW rises. Result outputs hold their values between reports.
- Reset mid-pulse: all state is discarded; the first complete rise-to-rise after re-arming yields the first report.

Test Plan:
- Nominal stream, high 875 clocks, period 500002 clocks, 5 pulses:
  - No report at the first rise.
  - Each later rise gives a one-cycle o_meas_valid with o_width=875, o_period=500002, o_pulse_good=1.
  - o_ok rises with the 3rd report (4th rise).
- o_ok=1, then one pulse with width 500:
  - That report has o_pulse_good=0 and o_width=500; o_ok drops the same cycle.
  - o_ok returns after 3 further good reports.
- Period 400000 and a 1-clock glitch pulse: each gives o_pulse_good=0 with the exact measured o_period / o_width=1.
- Pulses stop after a rise:
  - o_lost=1 and o_ok=0 exactly P_TIMEOUT clocks after the synchronised rise.
  - The next rise clears o_lost with no report; a report follows at the rise after that.
- Input stuck high after a rise: o_lost asserts at P_TIMEOUT; no fall or report is produced.
- i_rst pulsed mid-high with the input held high:
  - All outputs are 0 the next cycle and no rise is accepted until the input has gone low.
  - The first report comes at the second subsequent rise.
